// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two write ports, optional
// write-to-read bypass, a pending-write scoreboard and a post-reset
// zero-initialisation sweep. Reads are combinational; all state updates on clk.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_idx,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en0,
    input  logic                     wr_en1,
    input  logic [ADDR_W-1:0]        wr_idx0,
    input  logic [ADDR_W-1:0]        wr_idx1,
    input  logic [DATA_W-1:0]        wr_data0,
    input  logic [DATA_W-1:0]        wr_data1,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_idx,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [DEPTH-1:0]    r_busy;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_run_upd;
    logic                w_we0;
    logic                w_we1;
    logic [DEPTH-1:0]    w_busy_nxt;

    // Writes and scoreboard updates only take effect in RUN when no clear is requested
    assign w_run_upd = rst_n && (r_state == ST_RUN) && !clr_req;
    assign w_we0     = w_run_upd && wr_en0 && !((ZERO_REG != 0) && (wr_idx0 == '0));
    assign w_we1     = w_run_upd && wr_en1 && !((ZERO_REG != 0) && (wr_idx1 == '0));
    assign ready     = r_ready;

    // Next scoreboard value: writeback clears, issue sets (set wins), r0 never busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (wr_en0) w_busy_nxt[wr_idx0] = 1'b0;
        if (wr_en1) w_busy_nxt[wr_idx1] = 1'b0;
        if (sb_set) w_busy_nxt[sb_idx]  = 1'b1;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    // Storage array: sweep zeroes one entry per cycle in INIT; port 1 written last so it wins
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_INIT)) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_we0) r_mem[wr_idx0] <= wr_data0;
            if (w_we1) r_mem[wr_idx1] <= wr_data1;
        end
    end

    // Control FSM: INIT sweep, RUN operation, scoreboard and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_busy    <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        r_state   <= ST_INIT;
                        r_clr_cnt <= '0;
                        r_busy    <= '0;
                        r_ready   <= 1'b0;
                    end else begin
                        r_busy <= w_busy_nxt;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Per-port combinational read with zero-register, bypass and busy masking
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            automatic logic [ADDR_W-1:0] v_idx  = rd_idx[i*ADDR_W +: ADDR_W];
            automatic logic              v_hit1 = (BYPASS != 0) && wr_en1 && (wr_idx1 == v_idx);
            automatic logic              v_hit0 = (BYPASS != 0) && wr_en0 && (wr_idx0 == v_idx);
            if (r_ready) begin
                if ((ZERO_REG != 0) && (v_idx == '0))
                    rd_data[i*DATA_W +: DATA_W] = '0;
                else if (v_hit1)
                    rd_data[i*DATA_W +: DATA_W] = wr_data1;
                else if (v_hit0)
                    rd_data[i*DATA_W +: DATA_W] = wr_data0;
                else
                    rd_data[i*DATA_W +: DATA_W] = r_mem[v_idx];
                rd_busy[i] = (v_hit0 || v_hit1) ? 1'b0 : r_busy[v_idx];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected read data, busy
// and ready values per cycle; a negedge monitor pops and compares them.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst_n, clr_req, wr_en0, wr_en1, sb_set, ready;
    logic [11:0] rd_idx;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic [3:0]  wr_idx0, wr_idx1, sb_idx;
    logic [31:0] wr_data0, wr_data1;

    // Variant instance: 16-bit, 8 entries, 2 read ports, no zero reg, no bypass
    logic        b_rst_n, b_clr_req, b_wr_en0, b_wr_en1, b_sb_set, b_ready;
    logic [5:0]  b_rd_idx;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [2:0]  b_wr_idx0, b_wr_idx1, b_sb_idx;
    logic [15:0] b_wr_data0, b_wr_data1;

    reg_file_sb dut_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_idx0(wr_idx0), .wr_idx1(wr_idx1),
        .wr_data0(wr_data0), .wr_data1(wr_data1),
        .sb_set(sb_set), .sb_idx(sb_idx), .ready(ready)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .clr_req(b_clr_req),
        .rd_idx(b_rd_idx), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en0(b_wr_en0), .wr_en1(b_wr_en1), .wr_idx0(b_wr_idx0), .wr_idx1(b_wr_idx1),
        .wr_data0(b_wr_data0), .wr_data1(b_wr_data1),
        .sb_set(b_sb_set), .sb_idx(b_sb_idx), .ready(b_ready)
    );

    typedef struct {
        int          cyc;
        int          dut;   // 0 = default instance, 1 = variant
        int          kind;  // 0 = data, 1 = busy, 2 = ready
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(chk_t e);
        logic [31:0] v;
        v = '0;
        if (e.dut == 0) begin
            case (e.kind)
                0: v = rd_data[e.port*32 +: 32];
                1: v = {31'b0, rd_busy[e.port]};
                default: v = {31'b0, ready};
            endcase
        end else begin
            case (e.kind)
                0: v = {16'b0, b_rd_data[e.port*16 +: 16]};
                1: v = {31'b0, b_rd_busy[e.port]};
                default: v = {31'b0, b_ready};
            endcase
        end
        return v;
    endfunction

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            chk_t        e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", e.name, e.cyc, a, e.exp);
            end
        end
    end

    task automatic push(int dut, int kind, int port, logic [31:0] exp, string name);
        chk_t e;
        e.cyc = cyc; e.dut = dut; e.kind = kind; e.port = port; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        clr_req = 0; wr_en0 = 0; wr_en1 = 0; sb_set = 0;
        wr_idx0 = 0; wr_idx1 = 0; sb_idx = 0; wr_data0 = 0; wr_data1 = 0;
    endtask

    task automatic idle_b();
        b_clr_req = 0; b_wr_en0 = 0; b_wr_en1 = 0; b_sb_set = 0;
        b_wr_idx0 = 0; b_wr_idx1 = 0; b_sb_idx = 0; b_wr_data0 = 0; b_wr_data1 = 0;
    endtask

    task automatic set_rd(int a, int b, int c);
        rd_idx = {4'(c), 4'(b), 4'(a)};
    endtask

    task automatic sweep_a(string nm);
        for (int i = 1; i <= 16; i++) begin
            tick();
            push(0, 2, 0, (i == 16) ? 32'd1 : 32'd0, nm);
        end
    endtask

    initial begin
        rst_n = 0; b_rst_n = 0;
        idle_a(); idle_b();
        set_rd(0, 0, 0); b_rd_idx = '0;
        tick(); tick();
        push(0, 2, 0, 32'd0, "reset_ready");
        push(0, 0, 0, 32'd0, "reset_data");
        push(0, 1, 0, 32'd0, "reset_busy");
        rst_n = 1;
        sweep_a("init_ready");

        // Preload, then confirm the writes landed
        for (int k = 1; k <= 15; k += 2) begin
            wr_en0 = 1; wr_idx0 = 4'(k);     wr_data0 = 32'hA000_0000 + 32'(k);
            wr_en1 = 1; wr_idx1 = 4'(k + 1); wr_data1 = 32'hB000_0000 + 32'(k + 1);
            tick();
        end
        idle_a(); set_rd(1, 2, 15);
        push(0, 0, 0, 32'hA000_0001, "preload_r1");
        push(0, 0, 1, 32'hB000_0002, "preload_r2");
        push(0, 0, 2, 32'hA000_000F, "preload_r15");
        tick();

        // One-cycle reset pulse re-runs the sweep and zeroes everything
        rst_n = 0; tick();
        push(0, 2, 0, 32'd0, "pulse_ready_low");
        rst_n = 1;
        sweep_a("pulse_ready");
        for (int c = 0; c < 6; c++) begin
            set_rd(3*c, 3*c + 1, 3*c + 2);
            push(0, 0, 0, 32'd0, "swept_zero_p0");
            push(0, 0, 1, 32'd0, "swept_zero_p1");
            push(0, 0, 2, 32'd0, "swept_zero_p2");
            tick();
        end

        // Write r5 and attempt r0
        wr_en0 = 1; wr_idx0 = 5; wr_data0 = 32'hDEADBEEF;
        wr_en1 = 1; wr_idx1 = 0; wr_data1 = 32'h12345678;
        set_rd(0, 0, 0);
        push(0, 0, 0, 32'd0, "r0_bypass_blocked");
        tick(); idle_a();
        set_rd(5, 5, 5);
        for (int p = 0; p < 3; p++) push(0, 0, p, 32'hDEADBEEF, "r5_read");
        tick();
        set_rd(0, 0, 0);
        for (int p = 0; p < 3; p++) push(0, 0, p, 32'd0, "r0_read");
        tick();

        // Dual write collision with same-cycle bypass
        wr_en0 = 1; wr_idx0 = 7; wr_data0 = 32'h1111;
        wr_en1 = 1; wr_idx1 = 7; wr_data1 = 32'h2222;
        set_rd(7, 5, 5);
        push(0, 0, 0, 32'h2222, "collision_bypass");
        push(0, 0, 1, 32'hDEADBEEF, "collision_other");
        tick(); idle_a();
        wr_en0 = 1; wr_idx0 = 9; wr_data0 = 32'h99;
        set_rd(7, 7, 9);
        push(0, 0, 0, 32'h2222, "collision_stored");
        push(0, 0, 2, 32'h99, "bypass_port0");
        tick(); idle_a();
        set_rd(9, 9, 9);
        push(0, 0, 1, 32'h99, "r9_stored");
        tick();

        // Scoreboard set / clear / set-wins
        sb_set = 1; sb_idx = 3; set_rd(3, 4, 3);
        push(0, 1, 0, 32'd0, "sb_before_set");
        tick(); idle_a();
        push(0, 1, 0, 32'd1, "sb_r3_busy");
        push(0, 1, 1, 32'd0, "sb_r4_idle");
        tick();
        wr_en0 = 1; wr_idx0 = 3; wr_data0 = 32'hAA;
        push(0, 1, 0, 32'd0, "sb_wb_busy_masked");
        push(0, 0, 0, 32'hAA, "sb_wb_data_fwd");
        tick(); idle_a();
        push(0, 1, 0, 32'd0, "sb_cleared");
        push(0, 0, 0, 32'hAA, "sb_wb_stored");
        tick();
        sb_set = 1; sb_idx = 3; wr_en1 = 1; wr_idx1 = 3; wr_data1 = 32'hBB;
        push(0, 1, 0, 32'd0, "sb_setclr_fwd");
        tick(); idle_a();
        push(0, 1, 0, 32'd1, "sb_set_wins");
        push(0, 0, 0, 32'hBB, "sb_setclr_data");
        tick();
        sb_set = 1; sb_idx = 0; set_rd(0, 3, 3);
        tick(); idle_a();
        push(0, 1, 0, 32'd0, "sb_r0_never_busy");
        tick();

        // Reset at sweep count 9 restarts the sweep
        wr_en0 = 1; wr_idx0 = 5; wr_data0 = 32'hCAFEF00D;
        tick(); idle_a();
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 0; tick();
        push(0, 2, 0, 32'd0, "midsweep_ready_low");
        rst_n = 1;
        set_rd(5, 3, 5);
        for (int i = 1; i <= 16; i++) begin
            tick();
            push(0, 2, 0, (i == 16) ? 32'd1 : 32'd0, "midsweep_ready");
            if (i <= 3) begin
                push(0, 0, 0, 32'd0, "init_data_masked");
                push(0, 1, 1, 32'd0, "init_busy_masked");
            end
        end
        push(0, 0, 0, 32'd0, "midsweep_r5_zero");
        tick();

        // clr_req in RUN drops a concurrent write and clears busy
        sb_set = 1; sb_idx = 4;
        tick(); idle_a();
        set_rd(4, 4, 4);
        push(0, 1, 0, 32'd1, "pre_clr_busy");
        clr_req = 1; wr_en0 = 1; wr_idx0 = 2; wr_data0 = 32'h55;
        tick(); idle_a();
        push(0, 2, 0, 32'd0, "clr_ready_low");
        sweep_a("clr_ready");
        set_rd(2, 4, 2);
        push(0, 0, 0, 32'd0, "clr_r2_zero");
        push(0, 1, 1, 32'd0, "clr_r4_not_busy");
        tick();

        // Variant instance
        b_rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            push(1, 2, 0, (i == 8) ? 32'd1 : 32'd0, "b_ready");
        end
        b_wr_en0 = 1; b_wr_idx0 = 0; b_wr_data0 = 16'hBEEF;
        b_wr_en1 = 1; b_wr_idx1 = 6; b_wr_data1 = 16'h1234;
        b_rd_idx = {3'd6, 3'd0};
        push(1, 0, 0, 32'd0, "b_r0_old");
        push(1, 0, 1, 32'd0, "b_r6_old");
        tick(); idle_b();
        push(1, 0, 0, 32'h0000BEEF, "b_r0_new");
        push(1, 0, 1, 32'h00001234, "b_r6_new");
        tick();
        b_sb_set = 1; b_sb_idx = 2; b_rd_idx = {3'd2, 3'd2};
        tick(); idle_b();
        push(1, 1, 0, 32'd1, "b_sb_busy");
        b_wr_en0 = 1; b_wr_idx0 = 2; b_wr_data0 = 16'h0A0A;
        push(1, 1, 1, 32'd1, "b_no_bypass_busy");
        push(1, 0, 1, 32'd0, "b_no_bypass_data");
        tick(); idle_b();
        push(1, 1, 0, 32'd0, "b_sb_cleared");
        push(1, 0, 0, 32'h00000A0A, "b_wb_stored");
        tick(); tick();

        if (q.size() != 0) begin
            $display("FAIL unchecked_expectations: got %0d pending expected 0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
